id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_hit  input  1  advance enable; 1 = capture inputs, 0 = stall (hold outputs).
REQ-005 flush  input  1  bubble insert; 1 = clear control outputs only; tie to 0 when unused.
REQ-006 ctlwb_out  input  2  WB-stage control bits from decode.
REQ-007 ctlm_out  input  3  MEM-stage control bits.
REQ-008 ctlex_out  input  4  EX-stage control bits.
REQ-009 npc  input  32  next PC (PC+4).
REQ-010 readdata1  input  32  register file read port 1 (rs).
REQ-011 readdata2  input  32  register file read port 2 (rt).
REQ-012 signex_out  input  32  sign-extended immediate.
REQ-013 instr_2016  input  5  instruction field [20:16] (rt).
REQ-014 instr_1511  input  5  instruction field [15:11] (rd).
REQ-015 Registered outputs, same widths as their inputs: wb_ctlout 2, m_ctlout 3, ex_ctlout 4, npcout 32, rdata1out 32, rdata2out 32, s_extendout 32, instrout_2016 5, instrout_1511 5.

Function
REQ-016 All outputs SHALL come directly from flops; no combinational path from any input to any output.
REQ-017 Priority at each rising clk edge: rst > flush > data_hit.
REQ-018 rst=1: all outputs SHALL become 0 at that edge, regardless of data_hit and flush.
REQ-019 rst=0, flush=1: wb_ctlout, m_ctlout and ex_ctlout SHALL become 0; data and field outputs SHALL capture their inputs if data_hit=1, otherwise hold.
REQ-020 rst=0, flush=0, data_hit=1: every output SHALL take its input value; latency is exactly one clock edge.
REQ-021 rst=0, flush=0, data_hit=0: every output SHALL keep its previous value, for any number of cycles.
REQ-022 Input values wider than a port are truncated at the source by Verilog port rules; e.g. ctlwb_out driven with 4 yields 2'b00.
REQ-023 Input changes between edges SHALL have no effect on the outputs until the next qualifying edge.
REQ-024 Outputs SHALL initialise to 0 at time zero (power-up), so an un-reset bench sees 0 rather than X before the first capture.
REQ-025 If data_hit falls while rst=1, reset still applies. The first edge after rst deasserts follows REQ-019 to REQ-021.

Reset
REQ-026 Reset is synchronous: asserting rst between edges SHALL NOT change the outputs until the next rising edge.
REQ-027 Reset values: all nine outputs 0. Deasserting rst mid-stream resumes normal capture on the next edge with data_hit=1.

Verification
REQ-028 clk period 100 ns, first rising edge at 50 ns, rst=0, flush=0. Drive data_hit=1, ctlwb_out=4, ctlm_out=0, ctlex_out=3, npc=0, readdata1=4, readdata2=5, signex_out=2, instr_2016=5, instr_1511=0. Required response after the 50 ns edge: wb=0, m=0, ex=3, npcout=0, rdata1out=4, rdata2out=5, s_extendout=2, instrout_2016=5, instrout_1511=0.
REQ-029 At 100 ns set data_hit=0 and inputs m=3, ex=1, npc=4, rd2=2, instr_1511=1 -> after the 150 ns edge all outputs are unchanged from REQ-028.
REQ-030 At 200 ns set data_hit=1, m=3, ex=1, npc=4, readdata1=2, readdata2=2, signex_out=3, instr_2016=5, instr_1511=4. Required response after the 250 ns edge: m=3, ex=1, npcout=4, rdata1out=2, rdata2out=2, s_extendout=3, instrout_1511=4, wb=0.
REQ-031 With data_hit=1 and outputs non-zero, assert rst for one edge -> all outputs 0 at that edge. Assert rst mid-cycle -> outputs hold until the edge.
REQ-032 With data_hit=1, flush=1 and ex input 4'hF, rd1 input 32'hDEADBEEF -> ex_ctlout=0, wb=0, m=0, rdata1out=32'hDEADBEEF.
REQ-033 Assert rst=1 and flush=1 together with data_hit=0 -> all outputs 0 (reset wins).

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage control and operands for the execute stage.
// Supports stall (data_hit=0), bubble insertion (flush clears control only) and sync reset.
module id_ex_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_hit,
   input  logic        flush,
   input  logic [1:0]  ctlwb_out,
   input  logic [2:0]  ctlm_out,
   input  logic [3:0]  ctlex_out,
   input  logic [31:0] npc,
   input  logic [31:0] readdata1,
   input  logic [31:0] readdata2,
   input  logic [31:0] signex_out,
   input  logic [4:0]  instr_2016,
   input  logic [4:0]  instr_1511,
   output logic [1:0]  wb_ctlout,
   output logic [2:0]  m_ctlout,
   output logic [3:0]  ex_ctlout,
   output logic [31:0] npcout,
   output logic [31:0] rdata1out,
   output logic [31:0] rdata2out,
   output logic [31:0] s_extendout,
   output logic [4:0]  instrout_2016,
   output logic [4:0]  instrout_1511
);

   // Power-up value of zero so an un-reset pipeline shows bubbles rather than X.
   logic [1:0]  wb_q   = '0;
   logic [2:0]  m_q    = '0;
   logic [3:0]  ex_q   = '0;
   logic [31:0] npc_q  = '0;
   logic [31:0] rd1_q  = '0;
   logic [31:0] rd2_q  = '0;
   logic [31:0] sext_q = '0;
   logic [4:0]  rt_q   = '0;
   logic [4:0]  rd_q   = '0;

   // Control fields: flush forces a bubble even while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q <= '0;
         m_q  <= '0;
         ex_q <= '0;
      end else if (flush) begin
         wb_q <= '0;
         m_q  <= '0;
         ex_q <= '0;
      end else if (data_hit) begin
         wb_q <= ctlwb_out;
         m_q  <= ctlm_out;
         ex_q <= ctlex_out;
      end
   end

   // Data and register-field outputs ignore flush; only the stall gates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         npc_q  <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         sext_q <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
      end else if (data_hit) begin
         npc_q  <= npc;
         rd1_q  <= readdata1;
         rd2_q  <= readdata2;
         sext_q <= signex_out;
         rt_q   <= instr_2016;
         rd_q   <= instr_1511;
      end
   end

   assign wb_ctlout     = wb_q;
   assign m_ctlout      = m_q;
   assign ex_ctlout     = ex_q;
   assign npcout        = npc_q;
   assign rdata1out     = rd1_q;
   assign rdata2out     = rd2_q;
   assign s_extendout   = sext_q;
   assign instrout_2016 = rt_q;
   assign instrout_1511 = rd_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: reference model feeds an expected-value queue that is
// drained one entry per rising edge and compared against the registered outputs.
module tb_id_ex_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sx;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } st_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        data_hit = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  ctlwb_out = '0;
   logic [2:0]  ctlm_out = '0;
   logic [3:0]  ctlex_out = '0;
   logic [31:0] npc = '0;
   logic [31:0] readdata1 = '0;
   logic [31:0] readdata2 = '0;
   logic [31:0] signex_out = '0;
   logic [4:0]  instr_2016 = '0;
   logic [4:0]  instr_1511 = '0;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [3:0]  ex_ctlout;
   logic [31:0] npcout;
   logic [31:0] rdata1out;
   logic [31:0] rdata2out;
   logic [31:0] s_extendout;
   logic [4:0]  instrout_2016;
   logic [4:0]  instrout_1511;

   int unsigned checks = 0;
   int unsigned errors = 0;
   st_t         model_q = '0;
   st_t         exp_q[$];

   id_ex_reg dut (
      .clk           (clk),
      .rst           (rst),
      .data_hit      (data_hit),
      .flush         (flush),
      .ctlwb_out     (ctlwb_out),
      .ctlm_out      (ctlm_out),
      .ctlex_out     (ctlex_out),
      .npc           (npc),
      .readdata1     (readdata1),
      .readdata2     (readdata2),
      .signex_out    (signex_out),
      .instr_2016    (instr_2016),
      .instr_1511    (instr_1511),
      .wb_ctlout     (wb_ctlout),
      .m_ctlout      (m_ctlout),
      .ex_ctlout     (ex_ctlout),
      .npcout        (npcout),
      .rdata1out     (rdata1out),
      .rdata2out     (rdata2out),
      .s_extendout   (s_extendout),
      .instrout_2016 (instrout_2016),
      .instrout_1511 (instrout_1511)
   );

   always #50 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input st_t e);
      check_eq({tag, ".wb"},   32'(wb_ctlout),     32'(e.wb));
      check_eq({tag, ".m"},    32'(m_ctlout),      32'(e.m));
      check_eq({tag, ".ex"},   32'(ex_ctlout),     32'(e.ex));
      check_eq({tag, ".npc"},  npcout,             e.npc);
      check_eq({tag, ".rd1"},  rdata1out,          e.rd1);
      check_eq({tag, ".rd2"},  rdata2out,          e.rd2);
      check_eq({tag, ".sx"},   s_extendout,        e.sx);
      check_eq({tag, ".rt"},   32'(instrout_2016), 32'(e.rt));
      check_eq({tag, ".rd"},   32'(instrout_1511), 32'(e.rd));
   endtask

   function automatic st_t model_next(input st_t cur, input logic r, input logic f,
                                      input logic h, input st_t in);
      st_t n;
      n = cur;
      if (r) return '0;
      if (h) n = in;
      if (f) begin
         n.wb = '0;
         n.m  = '0;
         n.ex = '0;
      end
      return n;
   endfunction

   // Drive one set of inputs and queue the value the outputs must show after the next edge.
   task automatic drive(input logic r, input logic f, input logic h, input st_t in);
      rst        = r;
      flush      = f;
      data_hit   = h;
      ctlwb_out  = in.wb;
      ctlm_out   = in.m;
      ctlex_out  = in.ex;
      npc        = in.npc;
      readdata1  = in.rd1;
      readdata2  = in.rd2;
      signex_out = in.sx;
      instr_2016 = in.rt;
      instr_1511 = in.rd;
      model_q    = model_next(model_q, r, f, h, in);
      exp_q.push_back(model_q);
   endtask

   task automatic edge_check(input string tag);
      st_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got empty queue expected one entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_all(tag, e);
      end
   endtask

   function automatic st_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                              input logic [31:0] n, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] sx, input logic [4:0] rt, input logic [4:0] rd);
      st_t s;
      s.wb = wb; s.m = m; s.ex = ex; s.npc = n; s.rd1 = r1; s.rd2 = r2;
      s.sx = sx; s.rt = rt; s.rd = rd;
      return s;
   endfunction

   function automatic st_t rnd();
      return mk(2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                $urandom, 5'($urandom), 5'($urandom));
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      st_t prev;
      logic [2:0] wide_wb;
      #1;
      check_all("power_up", '0);

      // Directed sequence; ctlwb_out driven with 4 truncates to 2'b00.
      wide_wb = 3'd4;
      drive(0, 0, 1, mk(wide_wb[1:0], 3'd0, 4'd3, 32'd0, 32'd4, 32'd5, 32'd2, 5'd5, 5'd0));
      edge_check("capture1");
      check_eq("capture1.lit_ex", 32'(ex_ctlout), 32'd3);
      check_eq("capture1.lit_wb", 32'(wb_ctlout), 32'd0);
      #49;
      drive(0, 0, 0, mk(2'd0, 3'd3, 4'd1, 32'd4, 32'd4, 32'd2, 32'd2, 5'd5, 5'd1));
      edge_check("stall1");
      check_eq("stall1.lit_rd2", rdata2out, 32'd5);
      #49;
      drive(0, 0, 1, mk(2'd0, 3'd3, 4'd1, 32'd4, 32'd2, 32'd2, 32'd3, 5'd5, 5'd4));
      edge_check("capture2");
      check_eq("capture2.lit_m", 32'(m_ctlout), 32'd3);

      // Multi-cycle stall with inputs changing underneath.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 0, 0, rnd());
         edge_check("stall_n");
      end

      // Random traffic with occasional reset and flush.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               1'($urandom), rnd());
         edge_check("random");
      end

      // Reset asserted mid-cycle must not disturb outputs until the edge.
      @(negedge clk);
      drive(0, 0, 1, mk(2'd3, 3'd7, 4'd9, 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd9));
      edge_check("preload");
      #24;
      prev = model_q;
      drive(1, 0, 1, rnd());
      #24;
      check_all("rst_midcycle_hold", prev);
      edge_check("rst_edge");
      check_eq("rst_edge.lit_npc", npcout, 32'd0);

      // Resume after reset.
      @(negedge clk);
      drive(0, 0, 1, rnd());
      edge_check("resume");

      // Flush with capture: control cleared, data still loads.
      @(negedge clk);
      drive(0, 1, 1, mk(2'd3, 3'd5, 4'hF, 32'h100, 32'hDEADBEEF, 32'h1, 32'h2, 5'd3, 5'd4));
      edge_check("flush");
      check_eq("flush.lit_ex", 32'(ex_ctlout), 32'd0);
      check_eq("flush.lit_rd1", rdata1out, 32'hDEADBEEF);

      // Flush while stalled: control cleared, data held.
      @(negedge clk);
      drive(0, 0, 1, mk(2'd2, 3'd6, 4'd5, 32'h7, 32'h8, 32'h9, 32'hA, 5'd1, 5'd2));
      edge_check("preload2");
      @(negedge clk);
      drive(0, 1, 0, rnd());
      edge_check("flush_stall");
      check_eq("flush_stall.lit_npc", npcout, 32'h7);

      // Reset wins over flush with data_hit low.
      @(negedge clk);
      drive(0, 0, 1, mk(2'd1, 3'd2, 4'd3, 32'h5, 32'h6, 32'h7, 32'h8, 5'd9, 5'd10));
      edge_check("preload3");
      @(negedge clk);
      drive(1, 1, 0, rnd());
      edge_check("rst_flush");
      check_eq("rst_flush.lit_rd1", rdata1out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
